// File: rtl/mouse_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mouse_init_sequencer
// Brief    : PS/2 mouse bring-up (reset, BAT, ID, enable) with retry/timeout,
//            followed by 3-byte stream packet assembly.
// Revision : 1.0 - initial release
// ============================================================================
module mouse_init_sequencer #(
    parameter int TIMEOUT_CYCLES = 25000000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    output logic [7:0]  TxData,
    output logic        TxValid,
    input  logic        TxReady,
    input  logic [7:0]  RxData,
    input  logic        RxValid,
    output logic [23:0] PktData,
    output logic        PktValid,
    output logic        Streaming,
    output logic        Error,
    output logic [3:0]  State
);

    localparam int c_tmo_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_rty_w = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_rty_w:0]   c_max_rty  = (c_rty_w + 1)'(MAX_RETRIES);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_SEND_RST  = 4'd1,
        S_WAIT_ACK1 = 4'd2,
        S_WAIT_BAT  = 4'd3,
        S_WAIT_ID   = 4'd4,
        S_SEND_EN   = 4'd5,
        S_WAIT_ACK2 = 4'd6,
        S_STREAM    = 4'd7,
        S_FAIL      = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_next;
    state_t             w_pass_state;
    logic [c_rty_w-1:0] r_retry;
    logic [c_rty_w:0]   w_retry_inc;
    logic [c_tmo_w-1:0] r_tmo;
    logic [1:0]         r_idx;
    logic [7:0]         r_b0;
    logic [7:0]         r_b1;
    logic [23:0]        r_pkt_data;
    logic               r_pkt_valid;
    logic               w_is_wait;
    logic               w_timeout;
    logic               w_attempt_fail;
    logic [7:0]         w_expect;

    // Per-wait-state expected reply and the state a correct reply leads to
    always_comb begin
        w_is_wait    = 1'b0;
        w_expect     = 8'hFA;
        w_pass_state = r_state;
        case (r_state)
            S_WAIT_ACK1: begin w_is_wait = 1'b1; w_expect = 8'hFA; w_pass_state = S_WAIT_BAT; end
            S_WAIT_BAT:  begin w_is_wait = 1'b1; w_expect = 8'hAA; w_pass_state = S_WAIT_ID;  end
            S_WAIT_ID:   begin w_is_wait = 1'b1; w_expect = 8'h00; w_pass_state = S_SEND_EN;  end
            S_WAIT_ACK2: begin w_is_wait = 1'b1; w_expect = 8'hFA; w_pass_state = S_STREAM;   end
            default: ;
        endcase
    end

    always_comb begin
        w_next         = r_state;
        w_attempt_fail = 1'b0;
        w_timeout      = w_is_wait && !RxValid && (r_tmo == c_tmo_last);
        w_retry_inc    = {1'b0, r_retry} + 1'b1;
        if (Start) begin
            w_next = S_SEND_RST;
        end else if (w_is_wait) begin
            if (RxValid) begin
                if (RxData == w_expect) w_next = w_pass_state;
                else                    w_attempt_fail = 1'b1;
            end else if (w_timeout) begin
                w_attempt_fail = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE:     w_next = S_SEND_RST;
                S_SEND_RST: if (TxReady) w_next = S_WAIT_ACK1;
                S_SEND_EN:  if (TxReady) w_next = S_WAIT_ACK2;
                S_STREAM,
                S_FAIL:     w_next = r_state;
                default:    w_next = S_IDLE;
            endcase
        end
        if (w_attempt_fail) w_next = (w_retry_inc < c_max_rty) ? S_SEND_RST : S_FAIL;
    end

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_retry     <= '0;
            r_tmo       <= '0;
            r_idx       <= 2'd0;
            r_b0        <= 8'h00;
            r_b1        <= 8'h00;
            r_pkt_data  <= 24'h0;
            r_pkt_valid <= 1'b0;
        end else begin
            r_pkt_valid <= 1'b0;
            // Counter restarts on every state change, so each wait begins at zero
            if ((w_next != r_state) || !w_is_wait) r_tmo <= '0;
            else if (r_tmo != c_tmo_last)          r_tmo <= r_tmo + 1'b1;
            if (Start) begin
                r_retry <= '0;
                r_idx   <= 2'd0;
            end else begin
                if (w_attempt_fail) r_retry <= r_retry + 1'b1;
                if ((r_state == S_STREAM) && RxValid) begin
                    case (r_idx)
                        2'd0: if (RxData[3]) begin r_b0 <= RxData; r_idx <= 2'd1; end
                        2'd1: begin r_b1 <= RxData; r_idx <= 2'd2; end
                        default: begin
                            r_pkt_data  <= {RxData, r_b1, r_b0};
                            r_pkt_valid <= 1'b1;
                            r_idx       <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end

    // Start/Reset mask the offer immediately so no command escapes mid-restart
    assign TxValid   = ((r_state == S_SEND_RST) || (r_state == S_SEND_EN)) && !Start && !Reset;
    assign TxData    = (r_state == S_SEND_RST) ? 8'hFF :
                       (r_state == S_SEND_EN)  ? 8'hF4 : 8'h00;
    assign PktData   = r_pkt_data;
    assign PktValid  = r_pkt_valid;
    assign Streaming = (r_state == S_STREAM);
    assign Error     = (r_state == S_FAIL);
    assign State     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mouse_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mouse_init_sequencer
// Brief    : Self-checking bench: directed bring-up/packet/timeout/Start cases
//            plus randomized attempt scenarios against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mouse_init_sequencer;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int MAX_RETRIES    = 3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic        TxReady = 1'b0;
    logic [7:0]  RxData = 8'h00;
    logic        RxValid = 1'b0;
    logic [7:0]  TxData;
    logic        TxValid;
    logic [23:0] PktData;
    logic        PktValid;
    logic        Streaming;
    logic        Error;
    logic [3:0]  State;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [7:0]  tx_q[$];
    int          tx_cyc[$];
    logic [23:0] pkt_q[$];
    bit          rand_ready  = 1'b0;
    logic        ready_level = 1'b1;
    logic        prev_stall = 1'b0, prev_rst = 1'b1, prev_pv = 1'b0;
    logic [7:0]  prev_txd = 8'h00;

    mouse_init_sequencer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady),
        .RxData(RxData), .RxValid(RxValid),
        .PktData(PktData), .PktValid(PktValid),
        .Streaming(Streaming), .Error(Error), .State(State)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always begin
        @(posedge Clk);
        #1;
        TxReady = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Transfer log, packet log, one-cycle PktValid and offer-hold rules
    always @(negedge Clk) begin
        if (TxValid && TxReady) begin
            tx_q.push_back(TxData);
            tx_cyc.push_back(cyc);
        end
        if (PktValid) begin
            pkt_q.push_back(PktData);
            check_val("pkt_pulse", 32'(prev_pv), 32'd0);
        end
        if (prev_stall && !prev_rst && !Start && !Reset)
            check_val("tx_hold", 32'({TxValid, TxData}), 32'({1'b1, prev_txd}));
        prev_stall = TxValid && !TxReady;
        prev_rst   = Reset;
        prev_txd   = TxData;
        prev_pv    = PktValid;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        @(negedge Clk);
        #1;
    endtask

    task automatic do_reset(input bit chk);
        Reset = 1'b1; Start = 1'b0; RxValid = 1'b0;
        tick(); tick(); settle();
        if (chk) begin
            check_val("rst_state",  32'(State),     32'd0);
            check_val("rst_txv",    32'(TxValid),   32'd0);
            check_val("rst_txd",    32'(TxData),    32'd0);
            check_val("rst_pktv",   32'(PktValid),  32'd0);
            check_val("rst_pktd",   32'(PktData),   32'd0);
            check_val("rst_stream", 32'(Streaming), 32'd0);
            check_val("rst_err",    32'(Error),     32'd0);
        end
        tick();
        Reset = 1'b0;
        tx_q.delete(); tx_cyc.delete(); pkt_q.delete();
    endtask

    task automatic send_rx(input logic [7:0] b);
        RxData = b; RxValid = 1'b1;
        tick();
        RxValid = 1'b0;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin settle(); k++; end
        check_val("tx_count", 32'(tx_q.size()), 32'(n));
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int k = 0;
        while (State !== s && k < budget) begin settle(); k++; end
        check_val("state_reach", 32'(State), 32'(s));
    endtask

    task automatic bring_up();
        wait_tx(1, 50); tick(); send_rx(8'hFA);
        tick(); send_rx(8'hAA);
        tick(); send_rx(8'h00);
        wait_tx(2, 50); tick(); send_rx(8'hFA);
        settle();
        check_val("up_state",  32'(State),     32'd7);
        check_val("up_stream", 32'(Streaming), 32'd1);
        if (tx_q.size() >= 2) begin
            check_val("up_tx0", 32'(tx_q[0]), 32'hFF);
            check_val("up_tx1", 32'(tx_q[1]), 32'hF4);
        end
    endtask

    // Randomized bring-up attempts, then a random stream if init succeeded
    task automatic random_scenario();
        logic [7:0]  exp_tx[$];
        logic [7:0]  acc[$];
        logic [23:0] exp_pk[$];
        logic [7:0]  replies[4];
        logic [7:0]  b;
        int fails, fail_at, nb;
        bit by_timeout, failed, done;
        replies[0] = 8'hFA; replies[1] = 8'hAA; replies[2] = 8'h00; replies[3] = 8'hFA;
        fails = 0; done = 1'b0;
        rand_ready = 1'b0; ready_level = 1'b1;
        do_reset(1'b0);
        rand_ready = 1'b1;
        while (!done && fails < MAX_RETRIES) begin
            fail_at    = $urandom_range(0, 7);
            by_timeout = ($urandom_range(0, 3) == 0);
            failed     = 1'b0;
            for (int p = 0; p < 4 && !failed; p++) begin
                if (p == 0 || p == 3) begin
                    exp_tx.push_back((p == 0) ? 8'hFF : 8'hF4);
                    wait_tx(exp_tx.size(), 400);
                end
                repeat ($urandom_range(1, 30)) tick();
                if (p == fail_at) begin
                    failed = 1'b1; fails++;
                    if (!by_timeout) begin
                        b = 8'($urandom);
                        if (b == replies[p]) b = b ^ 8'h01;
                        send_rx(b);
                    end
                end else begin
                    send_rx(replies[p]);
                end
            end
            if (!failed) done = 1'b1;
        end
        if (done) begin
            wait_state(4'd7, 20);
            nb = $urandom_range(6, 15);
            pkt_q.delete();
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                if ($urandom_range(0, 1) == 1) b[3] = 1'b1;
                if (acc.size() != 0 || b[3]) acc.push_back(b);
                if (acc.size() == 3) begin
                    exp_pk.push_back({acc[2], acc[1], acc[0]});
                    acc.delete();
                end
                repeat ($urandom_range(0, 2)) tick();
                send_rx(b);
            end
            repeat (3) tick();
            settle();
            check_val("rs_pkt_n", 32'(pkt_q.size()), 32'(exp_pk.size()));
            for (int i = 0; i < exp_pk.size() && i < pkt_q.size(); i++)
                check_val("rs_pkt", 32'(pkt_q[i]), 32'(exp_pk[i]));
        end else begin
            wait_state(4'd8, 400);
            check_val("rs_err", 32'(Error), 32'd1);
        end
        check_val("rs_tx_n", 32'(tx_q.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            check_val("rs_tx", 32'(tx_q[i]), 32'(exp_tx[i]));
        rand_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and happy path
        do_reset(1'b1);
        bring_up();

        // Packet assembly
        pkt_q.delete();
        send_rx(8'h08); send_rx(8'h10); send_rx(8'hF0);
        settle();
        check_val("pkt_valid", 32'(PktValid), 32'd1);
        check_val("pkt_data",  32'(PktData),  32'hF01008);
        tick(); settle();
        check_val("pkt_valid_off", 32'(PktValid), 32'd0);

        // Resync: byte without bit3 dropped, earlier packet held meanwhile
        pkt_q.delete();
        send_rx(8'h00);
        settle();
        check_val("pkt_hold", 32'(PktData), 32'hF01008);
        send_rx(8'h09); send_rx(8'h01); send_rx(8'h02);
        settle();
        check_val("resync_data", 32'(PktData), 32'h020109);
        check_val("resync_n",    32'(pkt_q.size()), 32'd1);

        // Start mid-packet clears the index and restarts init
        send_rx(8'h08);
        tick();
        pulse_start();
        tx_q.delete();
        settle();
        check_val("start_state",  32'(State),     32'd1);
        check_val("start_stream", 32'(Streaming), 32'd0);
        bring_up();
        pkt_q.delete();
        send_rx(8'h18); send_rx(8'h20); send_rx(8'h30);
        settle();
        check_val("start_pkt", 32'(PktData), 32'h302018);
        check_val("start_pkt_n", 32'(pkt_q.size()), 32'd1);

        // Timeouts: each retry 100 cycles after its wait began, then FAIL
        ready_level = 1'b1;
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) begin
            wait_tx(k + 1, 300);
            repeat (100) tick();
            settle();
            check_val("tmo_hold", 32'(State), 32'd2);
            tick(); settle();
            check_val("tmo_exit", 32'(State), (k < 2) ? 32'd1 : 32'd8);
        end
        if (tx_cyc.size() >= 3) begin
            check_val("tmo_gap1", 32'(tx_cyc[1] - tx_cyc[0]), 32'd101);
            check_val("tmo_gap2", 32'(tx_cyc[2] - tx_cyc[1]), 32'd101);
        end
        check_val("fail_err", 32'(Error), 32'd1);
        repeat (20) tick();
        settle();
        check_val("fail_stay", 32'(State), 32'd8);
        check_val("fail_tx_n", 32'(tx_q.size()), 32'd3);

        // Start out of FAIL
        pulse_start();
        tx_q.delete();
        settle();
        check_val("fstart_err",   32'(Error), 32'd0);
        check_val("fstart_state", 32'(State), 32'd1);
        wait_tx(1, 10);
        if (tx_q.size() >= 1) check_val("fstart_tx", 32'(tx_q[0]), 32'hFF);

        // Unexpected byte counts as one failure: two timeouts later -> FAIL
        do_reset(1'b0);
        wait_tx(1, 20);
        tick();
        send_rx(8'hFE);
        settle();
        check_val("bad_state", 32'(State), 32'd1);
        wait_tx(2, 20);
        wait_tx(3, 300);
        wait_state(4'd8, 300);
        check_val("bad_tx_n", 32'(tx_q.size()), 32'd3);

        // Start coincident with the expected ACK wins
        do_reset(1'b0);
        wait_tx(1, 20);
        tick();
        Start = 1'b1; RxData = 8'hFA; RxValid = 1'b1;
        tick();
        Start = 1'b0; RxValid = 1'b0;
        settle();
        check_val("start_vs_rx", 32'(State), 32'd1);

        // Stalled offer: RxValid ignored, Reset drops TxValid
        ready_level = 1'b0;
        do_reset(1'b0);
        tick(); tick(); settle();
        check_val("stall_txv", 32'(TxValid), 32'd1);
        check_val("stall_txd", 32'(TxData),  32'hFF);
        tick();
        send_rx(8'hFA);
        settle();
        check_val("stall_rx_ign", 32'(State), 32'd1);
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        settle();
        check_val("midrst_txv",   32'(TxValid), 32'd0);
        check_val("midrst_state", 32'(State),   32'd0);
        tick(); settle();
        check_val("midrst_resend", 32'({State, TxValid}), 32'({4'd1, 1'b1}));
        check_val("midrst_tx_n",   32'(tx_q.size()), 32'd0);
        ready_level = 1'b1;

        for (int s = 0; s < 20; s++) random_scenario();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
